// File: rtl/npc_svm_sequencer_if.sv
// rtl/npc_svm_sequencer_if.sv - double-buffered config handshake channel for the SVM sequencer
interface npc_svm_sequencer_if #(
  parameter int CNT_W = 16,
  parameter int NSEG  = 4
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [1:0]            cfg_nseg;
  logic [5*NSEG-1:0]     cfg_states;
  logic [CNT_W*NSEG-1:0] cfg_dwell;

  modport master (output cfg_valid, cfg_nseg, cfg_states, cfg_dwell, input cfg_ready);
  modport slave  (input cfg_valid, cfg_nseg, cfg_states, cfg_dwell, output cfg_ready);
endinterface

// File: rtl/npc_svm_sequencer.sv
// rtl/npc_svm_sequencer.sv - centre-aligned NPC state sequencer with shadow config and trip latch
module npc_svm_sequencer #(
  parameter int         CNT_W      = 16,
  parameter int         NSEG       = 4,
  parameter logic [4:0] SAFE_STATE = 5'd0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               trip,
  input  logic               fault_clr,
  npc_svm_sequencer_if.slave cfg,
  output logic [4:0]         state,
  output logic [1:0]         seg_idx,
  output logic               dir,
  output logic               period_end,
  output logic               running,
  output logic               fault
);
  typedef enum logic [1:0] {IDLE, RUN, FAULT} fsm_t;

  fsm_t                  fsm_q, fsm_d;
  logic [1:0]            seg_q, seg_d;
  logic                  dir_q, dir_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4:0]            state_q, state_d;

  logic                  shadow_full, act_valid;
  logic [1:0]            sh_nseg, act_nseg;
  logic [5*NSEG-1:0]     sh_states, act_states;
  logic [CNT_W*NSEG-1:0] sh_dwell, act_dwell;

  logic                  swap, nx_valid, pe_w;
  logic [5*NSEG-1:0]     nx_states;
  logic [CNT_W*NSEG-1:0] nx_dwell;

  function automatic logic [CNT_W-1:0] eff_dwell(input logic [CNT_W*NSEG-1:0] d, input logic [1:0] k);
    logic [CNT_W-1:0] v;
    v = d[CNT_W*int'(k) +: CNT_W];
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  assign pe_w      = (fsm_q == RUN) && dir_q && (seg_q == 2'd0) && (cnt_q == CNT_W'(1));
  assign swap      = shadow_full && ((fsm_q == IDLE) || pe_w);
  // A restart in the swap cycle must already see the new config.
  assign nx_states = swap ? sh_states : act_states;
  assign nx_dwell  = swap ? sh_dwell  : act_dwell;
  assign nx_valid  = act_valid || swap;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_full <= 1'b0;
      act_valid   <= 1'b0;
    end else begin
      if (swap) begin
        act_nseg   <= sh_nseg;
        act_states <= sh_states;
        act_dwell  <= sh_dwell;
        act_valid  <= 1'b1;
      end
      if (cfg.cfg_valid && cfg.cfg_ready) begin
        sh_nseg     <= cfg.cfg_nseg;
        sh_states   <= cfg.cfg_states;
        sh_dwell    <= cfg.cfg_dwell;
        shadow_full <= 1'b1;
      end else if (swap) begin
        shadow_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      seg_q   <= 2'd0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      state_q <= SAFE_STATE;
    end else begin
      fsm_q   <= fsm_d;
      seg_q   <= seg_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    seg_d   = seg_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    case (fsm_q)
      IDLE: begin
        seg_d   = 2'd0;
        dir_d   = 1'b0;
        state_d = SAFE_STATE;
        if (en && nx_valid) begin
          fsm_d   = RUN;
          cnt_d   = eff_dwell(nx_dwell, 2'd0);
          state_d = nx_states[4:0];
        end
      end
      RUN: begin
        if (cnt_q > CNT_W'(1)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (pe_w) begin
          seg_d = 2'd0;
          dir_d = 1'b0;
          if (en) begin
            cnt_d   = eff_dwell(nx_dwell, 2'd0);
            state_d = nx_states[4:0];
          end else begin
            fsm_d   = IDLE;
            state_d = SAFE_STATE;
          end
        end else begin
          // Middle segment is visited twice: the turn-around keeps seg and flips dir.
          if (!dir_q) begin
            if (seg_q < act_nseg) seg_d = seg_q + 2'd1;
            else                  dir_d = 1'b1;
          end else begin
            seg_d = seg_q - 2'd1;
          end
          cnt_d   = eff_dwell(act_dwell, seg_d);
          state_d = act_states[5*int'(seg_d) +: 5];
        end
      end
      default: begin
        seg_d   = 2'd0;
        dir_d   = 1'b0;
        state_d = SAFE_STATE;
        if (fault_clr && !trip) fsm_d = IDLE;
      end
    endcase
    if (trip) begin
      fsm_d   = FAULT;
      seg_d   = 2'd0;
      dir_d   = 1'b0;
      state_d = SAFE_STATE;
    end
  end

  assign cfg.cfg_ready = !shadow_full;
  assign state         = state_q;
  assign seg_idx       = seg_q;
  assign dir           = dir_q;
  assign period_end    = pe_w;
  assign running       = (fsm_q == RUN);
  assign fault         = (fsm_q == FAULT);
endmodule

// File: tb/tb_npc_svm_sequencer.sv
// tb/tb_npc_svm_sequencer.sv - randomized self-checking bench for npc_svm_sequencer
module tb_npc_svm_sequencer;
  localparam int CNT_W = 16;
  localparam int NSEG  = 4;

  logic       clk = 1'b0;
  logic       rst, en, trip, fault_clr;
  logic [4:0] state;
  logic [1:0] seg_idx;
  logic       dir, period_end, running, fault;

  int tests = 0;
  int fails = 0;

  logic [1:0]  cur_n;
  logic [19:0] cur_s;
  logic [63:0] cur_d;
  int          exp_q[$];

  npc_svm_sequencer_if #(.CNT_W(CNT_W), .NSEG(NSEG)) cfg_if ();

  npc_svm_sequencer #(.CNT_W(CNT_W), .NSEG(NSEG), .SAFE_STATE(5'd0)) dut (
    .clk(clk), .rst(rst), .en(en), .trip(trip), .fault_clr(fault_clr),
    .cfg(cfg_if),
    .state(state), .seg_idx(seg_idx), .dir(dir), .period_end(period_end),
    .running(running), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int dwell_of(input logic [63:0] d, input int k);
    int v;
    v = int'(d[16*k +: 16]);
    return (v == 0) ? 1 : v;
  endfunction

  // Expected state code for every cycle of one period: forward then mirrored.
  function automatic void build_period(input logic [1:0] n, input logic [19:0] s, input logic [63:0] d);
    exp_q.delete();
    for (int k = 0; k <= int'(n); k++)
      for (int r = 0; r < dwell_of(d, k); r++) exp_q.push_back(int'(s[5*k +: 5]));
    for (int k = int'(n); k >= 0; k--)
      for (int r = 0; r < dwell_of(d, k); r++) exp_q.push_back(int'(s[5*k +: 5]));
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests++; if (state !== 5'd0) begin fails++; $display("FAIL reset_state got=%0d exp=0", state); end
    tests++; if (seg_idx !== 2'd0) begin fails++; $display("FAIL reset_seg got=%0d exp=0", seg_idx); end
    tests++; if (dir !== 1'b0) begin fails++; $display("FAIL reset_dir got=%0b exp=0", dir); end
    tests++; if (period_end !== 1'b0) begin fails++; $display("FAIL reset_pe got=%0b exp=0", period_end); end
    tests++; if (running !== 1'b0) begin fails++; $display("FAIL reset_running got=%0b exp=0", running); end
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL reset_fault got=%0b exp=0", fault); end
    tests++; if (cfg_if.cfg_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%0b exp=1", cfg_if.cfg_ready); end
  endtask

  task automatic test_basic();
    int t;
    int q[$];
    cur_n = 2'd1;
    cur_s = {10'd0, 5'd7, 5'd3};
    cur_d = {32'd0, 16'd2, 16'd4};
    rst = 1'b0;
    en  = 1'b1;
    cfg_if.cfg_nseg   = cur_n;
    cfg_if.cfg_states = cur_s;
    cfg_if.cfg_dwell  = cur_d;
    cfg_if.cfg_valid  = 1'b1;
    step();
    cfg_if.cfg_valid = 1'b0;
    tests++; if (state !== 5'd0 || running !== 1'b0) begin fails++; $display("FAIL basic_pre_run state=%0d running=%0b exp 0/0", state, running); end
    t = 0;
    while (!running && t < 8) begin step(); t++; end
    tests++; if (running !== 1'b1) begin fails++; $display("FAIL basic_start_timeout running=%0b exp=1", running); end
    build_period(cur_n, cur_s, cur_d);
    q = exp_q;
    tests++; if (q.size() != 12) begin fails++; $display("FAIL basic_model_len got=%0d exp=12", q.size()); end
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < q.size(); i++) begin
        tests++;
        if (state !== 5'(q[i]) || period_end !== (i == q.size() - 1)) begin
          fails++;
          $display("FAIL basic_seq p=%0d i=%0d state=%0d pe=%0b exp state=%0d pe=%0b", p, i, state, period_end, q[i], (i == q.size() - 1));
        end
        step();
      end
    end
  endtask

  task automatic test_cfg_swap(input logic [1:0] n, input logic [19:0] s, input logic [63:0] d);
    int q[$];
    build_period(cur_n, cur_s, cur_d);
    q = exp_q;
    for (int i = 0; i < q.size(); i++) begin
      tests++;
      if (state !== 5'(q[i]) || period_end !== (i == q.size() - 1)) begin
        fails++;
        $display("FAIL swap_old i=%0d state=%0d pe=%0b exp state=%0d pe=%0b", i, state, period_end, q[i], (i == q.size() - 1));
      end
      if (i == 1) begin
        tests++; if (cfg_if.cfg_ready !== 1'b1) begin fails++; $display("FAIL swap_ready_before got=%0b exp=1", cfg_if.cfg_ready); end
        cfg_if.cfg_nseg   = n;
        cfg_if.cfg_states = s;
        cfg_if.cfg_dwell  = d;
        cfg_if.cfg_valid  = 1'b1;
      end
      if (i == 2) cfg_if.cfg_valid = 1'b0;
      if (i >= 2) begin
        tests++; if (cfg_if.cfg_ready !== 1'b0) begin fails++; $display("FAIL swap_ready_held i=%0d got=%0b exp=0", i, cfg_if.cfg_ready); end
      end
      step();
    end
    cur_n = n;
    cur_s = s;
    cur_d = d;
    build_period(cur_n, cur_s, cur_d);
    q = exp_q;
    tests++; if (cfg_if.cfg_ready !== 1'b1) begin fails++; $display("FAIL swap_ready_after got=%0b exp=1", cfg_if.cfg_ready); end
    for (int i = 0; i < q.size(); i++) begin
      tests++;
      if (state !== 5'(q[i]) || period_end !== (i == q.size() - 1)) begin
        fails++;
        $display("FAIL swap_new i=%0d state=%0d pe=%0b exp state=%0d pe=%0b", i, state, period_end, q[i], (i == q.size() - 1));
      end
      step();
    end
  endtask

  task automatic test_dwell_zero();
    int cnt, seg1, exp_len;
    exp_len = 2 * (int'(cur_d[15:0]) + 1);
    cnt  = 0;
    seg1 = 0;
    while (cnt < 200) begin
      if (seg_idx == 2'd1) seg1++;
      cnt++;
      if (period_end) break;
      step();
    end
    step();
    tests++; if (cnt != exp_len) begin fails++; $display("FAIL dwell0_period got=%0d exp=%0d", cnt, exp_len); end
    tests++; if (seg1 != 2) begin fails++; $display("FAIL dwell0_seg1_cycles got=%0d exp=2", seg1); end
  endtask

  task automatic test_en_drop();
    int q[$];
    int k;
    build_period(cur_n, cur_s, cur_d);
    q = exp_q;
    k = $urandom_range(1, q.size() - 2);
    for (int i = 0; i < q.size(); i++) begin
      if (i == k) en = 1'b0;
      tests++;
      if (state !== 5'(q[i]) || period_end !== (i == q.size() - 1)) begin
        fails++;
        $display("FAIL endrop_seq i=%0d state=%0d pe=%0b exp state=%0d pe=%0b", i, state, period_end, q[i], (i == q.size() - 1));
      end
      step();
    end
    tests++; if (running !== 1'b0) begin fails++; $display("FAIL endrop_running got=%0b exp=0", running); end
    tests++; if (state !== 5'd0) begin fails++; $display("FAIL endrop_state got=%0d exp=0", state); end
    tests++; if (seg_idx !== 2'd0 || dir !== 1'b0) begin fails++; $display("FAIL endrop_seg got=%0d/%0b exp=0/0", seg_idx, dir); end
    step();
    step();
    tests++; if (running !== 1'b0 || state !== 5'd0) begin fails++; $display("FAIL endrop_idle_hold running=%0b state=%0d exp 0/0", running, state); end
    en = 1'b1;
    step();
    tests++; if (running !== 1'b1 || state !== 5'(q[0])) begin fails++; $display("FAIL endrop_restart running=%0b state=%0d exp 1/%0d", running, state, q[0]); end
  endtask

  task automatic test_trip();
    int q[$];
    int k;
    build_period(cur_n, cur_s, cur_d);
    q = exp_q;
    k = $urandom_range(1, q.size() - 2);
    for (int i = 0; i < k; i++) step();
    trip = 1'b1;
    step();
    tests++; if (state !== 5'd0 || fault !== 1'b1 || running !== 1'b0) begin fails++; $display("FAIL trip_entry state=%0d fault=%0b running=%0b exp 0/1/0", state, fault, running); end
    fault_clr = 1'b1;
    step();
    tests++; if (fault !== 1'b1 || state !== 5'd0) begin fails++; $display("FAIL trip_clr_ignored fault=%0b state=%0d exp 1/0", fault, state); end
    trip = 1'b0;
    step();
    tests++; if (fault !== 1'b0 || running !== 1'b0) begin fails++; $display("FAIL trip_clear fault=%0b running=%0b exp 0/0", fault, running); end
    fault_clr = 1'b0;
    step();
    tests++;
    if (running !== 1'b1 || seg_idx !== 2'd0 || dir !== 1'b0 || state !== 5'(q[0])) begin
      fails++;
      $display("FAIL trip_restart running=%0b seg=%0d dir=%0b state=%0d exp 1/0/0/%0d", running, seg_idx, dir, state, q[0]);
    end
    step();
    for (int i = 1; i < q.size(); i++) begin
      tests++;
      if (state !== 5'(q[i]) || period_end !== (i == q.size() - 1)) begin
        fails++;
        $display("FAIL trip_resume i=%0d state=%0d pe=%0b exp state=%0d pe=%0b", i, state, period_end, q[i], (i == q.size() - 1));
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    step();
    cfg_if.cfg_nseg   = 2'($urandom_range(0, 3));
    cfg_if.cfg_states = 20'($urandom);
    cfg_if.cfg_dwell  = {32'($urandom), 32'($urandom)};
    cfg_if.cfg_valid  = 1'b1;
    step();
    cfg_if.cfg_valid = 1'b0;
    tests++; if (cfg_if.cfg_ready !== 1'b0) begin fails++; $display("FAIL rstmid_shadow_full ready=%0b exp=0", cfg_if.cfg_ready); end
    rst = 1'b1;
    step();
    tests++;
    if (state !== 5'd0 || seg_idx !== 2'd0 || dir !== 1'b0 || period_end !== 1'b0 ||
        running !== 1'b0 || fault !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_outputs state=%0d seg=%0d dir=%0b pe=%0b run=%0b fault=%0b ready=%0b exp 0/0/0/0/0/0/1",
               state, seg_idx, dir, period_end, running, fault, cfg_if.cfg_ready);
    end
    rst = 1'b0;
    en  = 1'b1;
    step();
    step();
    step();
    tests++; if (running !== 1'b0 || state !== 5'd0) begin fails++; $display("FAIL rstmid_no_active running=%0b state=%0d exp 0/0", running, state); end
    en = 1'b0;
  endtask

  initial begin
    logic [1:0]  rn;
    logic [19:0] rs;
    logic [63:0] rd;
    rst = 1'b1;
    en = 1'b0;
    trip = 1'b0;
    fault_clr = 1'b0;
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_nseg   = 2'd0;
    cfg_if.cfg_states = '0;
    cfg_if.cfg_dwell  = '0;

    test_reset();
    test_basic();

    rs = 20'($urandom);
    rd = {32'd0, 16'd0, 16'($urandom_range(1, 5))};
    test_cfg_swap(2'd1, rs, rd);
    test_dwell_zero();

    for (int r = 0; r < 6; r++) begin
      rn = 2'($urandom_range(0, 3));
      rs = 20'($urandom);
      for (int k = 0; k < 4; k++) rd[16*k +: 16] = 16'($urandom_range(0, 6));
      rd[15:0] = 16'($urandom_range(2, 6));
      test_cfg_swap(rn, rs, rd);
    end

    test_en_drop();
    test_trip();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
